// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, default line terminator and
// the width of one buffered receive entry ({fe, pe, data}).
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_e;

    localparam int         DEFAULT_DBIT = 8;
    localparam logic [7:0] DEFAULT_TERM = 8'h0D;
    localparam int         ENTRY_W      = DEFAULT_DBIT + 2;

    // Width of a stored entry: data bits plus parity and framing flags.
    function automatic int entry_width(input int dbit);
        return dbit + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port
// and one asynchronous read port so the head entry falls through.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBIT       = DEFAULT_DBIT,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [entry_width(DBIT)-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [entry_width(DBIT)-1:0]  rd_data
);

    localparam int EW    = entry_width(DBIT);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [EW-1:0] mem_q [DEPTH];

    // Store the incoming entry; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver. Characters are
// captured one cycle after rx_done_tick so the late framing flag lines up,
// then stored with their error flags. Tracks overrun and complete lines.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int              DBIT       = DEFAULT_DBIT,
    parameter int              ADDR_WIDTH = 4,
    parameter logic [DBIT-1:0] TERM       = DBIT'(DEFAULT_TERM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_done_tick,
    input  logic [DBIT-1:0]       din,
    input  logic                  e_parity,
    input  logic                  e_frame,
    input  logic                  rd,
    input  logic                  clr_overrun,
    output logic [DBIT-1:0]       dout,
    output logic                  dout_pe,
    output logic                  dout_fe,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   line_count,
    output logic                  overrun
);

    localparam int                EW      = entry_width(DBIT);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] line_count_q, line_count_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;

    logic                wr_en;
    logic                pop;
    logic                term_in;
    logic                term_out;
    logic [EW-1:0]       wr_data;
    logic [EW-1:0]       rd_data;

    // Status comes straight from the registered pointers, so rd never
    // reaches these outputs combinationally.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign count      = wr_ptr_q - rd_ptr_q;
    assign line_count = line_count_q;
    assign overrun    = overrun_q;

    assign wr_data = {e_frame, e_parity, din};
    assign dout    = rd_data[DBIT-1:0];
    assign dout_pe = rd_data[DBIT];
    assign dout_fe = rd_data[DBIT+1];

    // Next-state for capture, pointers, terminator count and overrun.
    always_comb begin
        pending_d    = rx_done_tick;
        pop          = rd && !empty;
        wr_en        = pending_q && (!full || pop);
        wr_ptr_d     = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d     = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        term_in      = wr_en && (din == TERM) && !e_frame;
        term_out     = pop && (dout == TERM) && !dout_fe;
        line_count_d = line_count_q;
        if (term_in && !term_out) begin
            line_count_d = line_count_q + PTR_ONE;
        end else if (!term_in && term_out) begin
            line_count_d = line_count_q - PTR_ONE;
        end
        overrun_d = overrun_q;
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (pending_q && full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    // Control registers; reset discards any character still pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            line_count_q <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            line_count_q <= line_count_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    uart_rx_fifo_mem #(
        .DBIT       (DBIT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && !reset),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based model of the buffer is checked
// against the DUT every cycle, alongside hand-computed directed checks.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] din;
    logic       e_parity;
    logic       e_frame;
    logic       rd;
    logic       clr_overrun;
    logic [7:0] dout;
    logic       dout_pe;
    logic       dout_fe;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic [4:0] line_count;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    // Model state: stored entries as {fe, pe, data}, capture flag, overrun.
    logic [9:0] mq[$];
    bit         m_pending = 0;
    bit         m_overrun = 0;

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .e_parity     (e_parity),
        .e_frame      (e_frame),
        .rd           (rd),
        .clr_overrun  (clr_overrun),
        .dout         (dout),
        .dout_pe      (dout_pe),
        .dout_fe      (dout_fe),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .line_count   (line_count),
        .overrun      (overrun)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of inputs, then return just after the following rising edge.
    task automatic applyStimulus(input logic rst, input logic tick, input logic [7:0] d,
                                 input logic pe, input logic fe, input logic rdv,
                                 input logic clr);
        reset        = rst;
        rx_done_tick = tick;
        din          = d;
        e_parity     = pe;
        e_frame      = fe;
        rd           = rdv;
        clr_overrun  = clr;
        @(posedge clk);
        #1;
    endtask

    // Receiver-style character: tick cycle, then the framing flag a cycle later.
    task automatic sendChar(input logic [7:0] d, input logic pe, input logic fe,
                            input logic rd_in_pending);
        applyStimulus(0, 1, d, pe, 0, 0, 0);
        applyStimulus(0, 0, d, pe, fe, rd_in_pending, 0);
    endtask

    task automatic popOne();
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 0);
    endtask

    // Behavioural model: queue semantics applied to the inputs seen at each edge.
    always @(posedge clk) begin
        bit do_pop;
        bit was_full;
        bit set_ov;
        if (reset) begin
            mq.delete();
            m_pending = 0;
            m_overrun = 0;
        end else begin
            do_pop   = rd && (mq.size() != 0);
            was_full = (mq.size() == DEPTH);
            set_ov   = 0;
            if (do_pop) void'(mq.pop_front());
            if (m_pending) begin
                if (!was_full || do_pop) mq.push_back({e_frame, e_parity, din});
                else set_ov = 1;
            end
            if (clr_overrun) m_overrun = 0;
            if (set_ov) m_overrun = 1;
            m_pending = rx_done_tick;
        end
    end

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        int lines;
        if (check_en) begin
            lines = 0;
            foreach (mq[i]) if (mq[i][7:0] == 8'h0D && !mq[i][9]) lines++;
            checkOutput("m_empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("m_full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("m_count", 32'(count), 32'(mq.size()));
            checkOutput("m_line_count", 32'(line_count), 32'(lines));
            checkOutput("m_overrun", 32'(overrun), 32'(m_overrun));
            if (mq.size() != 0)
                checkOutput("m_head", 32'({dout_fe, dout_pe, dout}), 32'(mq[0]));
        end
    end

    initial begin
        reset = 1; rx_done_tick = 0; din = 0; e_parity = 0; e_frame = 0;
        rd = 0; clr_overrun = 0;
        applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0, 0, 0);
        check_en = 1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);

        $display("[TB] reset state");
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_line_count", 32'(line_count), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);

        $display("[TB] single character and pop");
        sendChar(8'h41, 0, 0, 0);
        checkOutput("w41_empty", 32'(empty), 32'd0);
        checkOutput("w41_dout", 32'(dout), 32'h41);
        checkOutput("w41_count", 32'(count), 32'd1);
        popOne();
        checkOutput("pop41_empty", 32'(empty), 32'd1);
        sendChar(8'h42, 0, 0, 1);
        checkOutput("rd_when_empty_count", 32'(count), 32'd1);
        popOne();

        $display("[TB] error flags");
        sendChar(8'h55, 0, 1, 0);
        checkOutput("fe_flag", 32'(dout_fe), 32'd1);
        checkOutput("fe_pe_clear", 32'(dout_pe), 32'd0);
        popOne();
        sendChar(8'h33, 1, 0, 0);
        checkOutput("pe_flag", 32'(dout_pe), 32'd1);
        checkOutput("pe_fe_clear", 32'(dout_fe), 32'd0);
        popOne();

        $display("[TB] fill, overrun, ordered drain");
        for (int i = 0; i < DEPTH; i++) sendChar(8'(i), 0, 0, 0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        sendChar(8'hFF, 0, 0, 0);
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        checkOutput("ovr_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_order", 32'(dout), 32'(i));
            popOne();
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);

        $display("[TB] overrun priority and write+pop when full");
        for (int i = 0; i < DEPTH; i++) sendChar(8'(i), 0, 0, 0);
        applyStimulus(0, 1, 8'hEE, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'hEE, 0, 0, 0, 1);
        checkOutput("ovr_priority", 32'(overrun), 32'd1);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 1);
        checkOutput("ovr_clr2", 32'(overrun), 32'd0);
        sendChar(8'hAA, 0, 0, 1);
        checkOutput("wp_full", 32'(full), 32'd1);
        checkOutput("wp_count", 32'(count), 32'd16);
        checkOutput("wp_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            checkOutput("wp_order", 32'(dout), 32'(i));
            popOne();
        end
        checkOutput("wp_last", 32'(dout), 32'hAA);
        popOne();
        checkOutput("wp_empty", 32'(empty), 32'd1);

        $display("[TB] line counting");
        sendChar(8'h4F, 0, 0, 0);
        sendChar(8'h4B, 0, 0, 0);
        sendChar(8'h0D, 0, 0, 0);
        sendChar(8'h3E, 0, 0, 0);
        checkOutput("lc_one", 32'(line_count), 32'd1);
        sendChar(8'h0D, 0, 1, 0);
        checkOutput("lc_fe_ignored", 32'(line_count), 32'd1);
        popOne();
        popOne();
        checkOutput("lc_before_pop", 32'(line_count), 32'd1);
        sendChar(8'h0D, 0, 0, 1);
        checkOutput("lc_push_pop_same", 32'(line_count), 32'd1);
        popOne();
        popOne();
        popOne();
        checkOutput("lc_drained", 32'(line_count), 32'd0);
        checkOutput("lc_empty", 32'(empty), 32'd1);

        $display("[TB] back-to-back ticks");
        applyStimulus(0, 1, 8'hA1, 0, 0, 0, 0);
        applyStimulus(0, 1, 8'hA1, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'hA1, 0, 0, 0, 0);
        checkOutput("b2b_count", 32'(count), 32'd2);
        popOne();
        popOne();

        $display("[TB] reset while pending");
        sendChar(8'h0D, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) sendChar(8'h20, 0, 0, 0);
        applyStimulus(0, 1, 8'h77, 0, 0, 0, 0);
        applyStimulus(1, 0, 8'h77, 0, 0, 0, 0);
        checkOutput("rp_empty", 32'(empty), 32'd1);
        checkOutput("rp_full", 32'(full), 32'd0);
        checkOutput("rp_count", 32'(count), 32'd0);
        checkOutput("rp_line_count", 32'(line_count), 32'd0);
        checkOutput("rp_overrun", 32'(overrun), 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("rp_nothing_written", 32'(count), 32'd0);

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer directly downstream of the UART receiver. It captures each received character together with its parity-error and framing-error flags into a first-word-fall-through FIFO. It also maintains a sticky overrun flag and a count of buffered complete lines, terminated by a configurable byte. The host-side consumer (command/response parser) drains it with a single-cycle pop strobe.

## Interface
- `DBIT`, 8, data bits per entry; matches the receiver's `dout` width.
- `ADDR_WIDTH`, 4, FIFO depth = 2^ADDR_WIDTH entries.
- `TERM`, 8'h0D, line-terminator byte value.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_done_tick`  in  1  one-cycle strobe from receiver: character complete.
- `din`  in  DBIT  received character; stable from `rx_done_tick` until the next character.
- `e_parity`  in  1  receiver parity error for the current character.
- `e_frame`  in  1  receiver framing error; valid from the cycle after `rx_done_tick`.
- `rd`  in  1  pop strobe; ignored when `empty`.
- `clr_overrun`  in  1  clears `overrun`.
- `dout`  out  DBIT  head entry data (FWFT).
- `dout_pe`, `dout_fe`  out  1 each  head entry parity/framing flags.
- `empty`, `full`  out  1 each  FIFO status.
- `count`  out  ADDR_WIDTH+1  entries stored.
- `line_count`  out  ADDR_WIDTH+1  stored entries equal to `TERM` with `fe`=0.
- `overrun`  out  1  sticky: a character was dropped because the FIFO was full.

## Operation
- Capture stage:
  - `rx_done_tick` sets a one-cycle `pending` register.
  - In the cycle `pending` is high, `din`, `e_parity` and `e_frame` are sampled and written.
  - This compensates for `e_frame` being registered one cycle late in the receiver.
- Write when `pending` and not full: store {fe, pe, data} at `wr_ptr`; `wr_ptr`++ (wraps mod depth).
- Write when `pending` and full, with no simultaneous pop: the entry is dropped and `overrun` is set.
- Pop when `rd` and not empty: `rd_ptr`++ (wraps).
- Outputs `dout`/`dout_pe`/`dout_fe` read combinationally at `rd_ptr`. Their value is don't-care when empty.
- Simultaneous write and pop:
  - Both are performed; `count` is unchanged.
  - This holds when full: the pop frees the slot and there is no overrun.
  - When empty, only the write is performed; the pop is ignored.
- Pointers are ADDR_WIDTH+1 bits, with the extra MSB used for wrap:
  - `full` = MSBs differ and addresses equal.
  - `empty` = pointers equal.
  - `count` = `wr_ptr` − `rd_ptr`, modulo 2^(ADDR_WIDTH+1).
- `line_count` tracks terminators:
  - +1 on a committed write of `TERM` with fe=0.
  - −1 on a pop of such an entry.
  - Unchanged if both happen in the same cycle.
  - A dropped write never counts.
- `overrun`: set has priority over `clr_overrun` in the same cycle.
- Reset is synchronous and aborts everything:
  - Pointers, `pending`, `count`, `line_count` and `overrun` are cleared to 0.
  - The memory contents are not cleared.
  - A character pending at reset is discarded.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `line_count`=0, `overrun`=0. `dout*` are don't-care.
- Write latency:
  - `rx_done_tick` is high in cycle T, so `pending` is high in T+1.
  - The entry is visible in T+2: `empty`=0, `count`+1, `dout` valid.
- Pop: with `rd` high in cycle R, the next entry appears on `dout` and `count` drops in R+1.
- Throughput: one write and one pop per cycle. Back-to-back `rx_done_tick` is accepted, one per cycle.
- All outputs except `dout*` are registered or derived directly from registers. There is no combinational path from `rd` to any output.

## Structure
- Shared package `uart_pkg`:
  - parity-mode encodings (0 none, 1 even, 2 odd);
  - default `TERM`;
  - entry width constant DBIT+2.
- One sub-module, `uart_rx_fifo_mem`: a 2^ADDR_WIDTH × (DBIT+2) register array with one synchronous write port and one asynchronous read port.
- Control (pointers, `pending`, counters, flags) lives in `uart_rx_fifo`.

## Test plan
- Reset, then pulse `rx_done_tick` with `din`=8'h41, `e_frame`=0. Expect `empty`=0 two cycles later, `dout`=8'h41, `count`=1. Then `rd` → `empty`=1 the next cycle.
- Drive `e_frame`=1 only in the cycle after `rx_done_tick` (`din`=8'h55). Expect `dout_fe`=1. Drive `e_parity`=1 → `dout_pe`=1.
- Write 16 bytes 8'h00..8'h0F (ADDR_WIDTH=4), giving `full`=1 and `count`=16. Write a 17th (8'hFF) → `overrun`=1, `count`=16, and pops return 00..0F in order. `clr_overrun` → 0.
- Fill the FIFO, then in a single cycle commit a write and assert `rd`. Expect `full`=1, `count`=16, `overrun`=0, and the new byte last out.
- Write "OK\r>" (4F 4B 0D 3E) → `line_count`=1. Write 0D with `e_frame`=1 → `line_count` stays 1. Pop through the first 0D → `line_count`=0.
- Assert `reset` in the cycle `pending` is high → nothing is written, and all outputs return to reset values.
